// File: rtl/ram_dp.sv
// True dual-port byte-strobed RAM with valid/ready requests, port A collision priority,
// selectable read-during-write result and an optional output register stage.
module ram_dp #(
   parameter int    DEPTH         = 16384,
   parameter int    ADDRESS_WIDTH = $clog2(DEPTH),
   parameter int    DATA_WIDTH    = 32,
   parameter int    BYTES         = DATA_WIDTH / 8,
   parameter int    OUT_REG       = 0,
   parameter int    RDW_MODE      = 0,
   parameter string INIT_FILE     = ""
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     a_req_valid,
   output logic                     a_req_ready,
   input  logic [ADDRESS_WIDTH-1:0] a_addr,
   input  logic [BYTES-1:0]         a_we,
   input  logic [DATA_WIDTH-1:0]    a_wdata,
   output logic                     a_rsp_valid,
   output logic [DATA_WIDTH-1:0]    a_rdata,
   input  logic                     b_req_valid,
   output logic                     b_req_ready,
   input  logic [ADDRESS_WIDTH-1:0] b_addr,
   input  logic [BYTES-1:0]         b_we,
   input  logic [DATA_WIDTH-1:0]    b_wdata,
   output logic                     b_rsp_valid,
   output logic [DATA_WIDTH-1:0]    b_rdata
);

   localparam bit FULL_RANGE = (DEPTH == (1 << ADDRESS_WIDTH));

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic a_acc, b_acc, a_in_range, b_in_range;
   logic a_val_reg, b_val_reg;
   logic [DATA_WIDTH-1:0] a_old_reg, b_old_reg, a_wdata_reg, b_wdata_reg;
   logic [BYTES-1:0]      a_we_reg, b_we_reg;
   logic [DATA_WIDTH-1:0] a_merged, b_merged;

   generate
      if (FULL_RANGE) begin : g_full
         assign a_in_range = 1'b1;
         assign b_in_range = 1'b1;
      end else begin : g_partial
         localparam logic [ADDRESS_WIDTH:0] DEPTH_LIM = (ADDRESS_WIDTH + 1)'(DEPTH);
         assign a_in_range = ({1'b0, a_addr} < DEPTH_LIM);
         assign b_in_range = ({1'b0, b_addr} < DEPTH_LIM);
      end
   endgenerate

   // B yields to A only when the shared word is being written by either side.
   assign a_req_ready = 1'b1;
   assign b_req_ready = !(a_req_valid && b_req_valid && (a_addr == b_addr) &&
                          ((|a_we) || (|b_we)));
   assign a_acc = a_req_valid && rst_n;
   assign b_acc = b_req_valid && b_req_ready && rst_n;

   always_ff @(posedge clk) begin
      for (int i = 0; i < BYTES; i++) begin
         if (a_acc && a_in_range && a_we[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
         if (b_acc && b_in_range && b_we[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
      end
   end

   // Read stage captures only on accept so its contents persist between responses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_val_reg   <= 1'b0;
         b_val_reg   <= 1'b0;
         a_old_reg   <= '0;
         b_old_reg   <= '0;
         a_we_reg    <= '0;
         b_we_reg    <= '0;
         a_wdata_reg <= '0;
         b_wdata_reg <= '0;
      end else begin
         a_val_reg <= a_acc;
         b_val_reg <= b_acc;
         if (a_acc) begin
            a_old_reg   <= mem[a_addr];
            a_we_reg    <= a_we;
            a_wdata_reg <= a_wdata;
         end
         if (b_acc) begin
            b_old_reg   <= mem[b_addr];
            b_we_reg    <= b_we;
            b_wdata_reg <= b_wdata;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < BYTES; gi++) begin : g_merge
         assign a_merged[8*gi +: 8] = (RDW_MODE != 0 && a_we_reg[gi]) ?
                                      a_wdata_reg[8*gi +: 8] : a_old_reg[8*gi +: 8];
         assign b_merged[8*gi +: 8] = (RDW_MODE != 0 && b_we_reg[gi]) ?
                                      b_wdata_reg[8*gi +: 8] : b_old_reg[8*gi +: 8];
      end

      if (OUT_REG != 0) begin : g_out_reg
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               a_rsp_valid <= 1'b0;
               b_rsp_valid <= 1'b0;
               a_rdata     <= '0;
               b_rdata     <= '0;
            end else begin
               a_rsp_valid <= a_val_reg;
               b_rsp_valid <= b_val_reg;
               if (a_val_reg) a_rdata <= a_merged;
               if (b_val_reg) b_rdata <= b_merged;
            end
         end
      end else begin : g_no_out_reg
         assign a_rsp_valid = a_val_reg;
         assign b_rsp_valid = b_val_reg;
         assign a_rdata     = a_merged;
         assign b_rdata     = b_merged;
      end
   endgenerate

endmodule

// File: tb/tb_ram_dp.sv
// Two ram_dp instances (latency 1 / read-first and latency 2 / write-first) driven in lockstep
// and compared every cycle against a word-array reference with per-accept response history.
module tb_ram_dp;
   localparam int H = 4096;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_req_valid = 1'b0, b_req_valid = 1'b0;
   logic [7:0]  a_addr = '0, b_addr = '0;
   logic [3:0]  a_we = '0, b_we = '0;
   logic [31:0] a_wdata = '0, b_wdata = '0;

   logic        a_ready [2];
   logic        b_ready [2];
   logic        rsp_v [2][2];
   logic [31:0] rsp_d [2][2];

   always #5 clk = ~clk;

   ram_dp #(.DEPTH(256), .OUT_REG(0), .RDW_MODE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .a_req_valid(a_req_valid), .a_req_ready(a_ready[0]), .a_addr(a_addr), .a_we(a_we),
      .a_wdata(a_wdata), .a_rsp_valid(rsp_v[0][0]), .a_rdata(rsp_d[0][0]),
      .b_req_valid(b_req_valid), .b_req_ready(b_ready[0]), .b_addr(b_addr), .b_we(b_we),
      .b_wdata(b_wdata), .b_rsp_valid(rsp_v[0][1]), .b_rdata(rsp_d[0][1]));

   ram_dp #(.DEPTH(256), .OUT_REG(1), .RDW_MODE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .a_req_valid(a_req_valid), .a_req_ready(a_ready[1]), .a_addr(a_addr), .a_we(a_we),
      .a_wdata(a_wdata), .a_rsp_valid(rsp_v[1][0]), .a_rdata(rsp_d[1][0]),
      .b_req_valid(b_req_valid), .b_req_ready(b_ready[1]), .b_addr(b_addr), .b_we(b_we),
      .b_wdata(b_wdata), .b_rsp_valid(rsp_v[1][1]), .b_rdata(rsp_d[1][1]));

   int          vectors = 0, miscompares = 0, n = 0;
   logic [31:0] mm [256];
   bit          acc_h [2][H];
   logic [31:0] dat_h [2][2][H];
   bit          rst_h [H];
   logic [31:0] last [2][2];
   logic        b_ready_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      vectors++;
      assert (obs === want) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] we);
      logic [31:0] mask;
      mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
      return (old & ~mask) | (wd & mask);
   endfunction

   // One clock: check ready before the edge, update the model at the edge, check outputs after.
   task automatic step();
      bit coll, acc_a, acc_b;
      int idx, m, lat;
      bit ev;
      #3;
      coll = a_req_valid && b_req_valid && (a_addr == b_addr) && (a_we != 0 || b_we != 0);
      b_ready_seen = b_ready[0];
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("a_ready dut%0d", d), a_ready[d], 1);
         chk($sformatf("b_ready dut%0d", d), b_ready[d], !coll);
      end
      @(posedge clk);
      n++;
      idx = n % H;
      rst_h[idx] = !rst_n;
      acc_a = rst_n && a_req_valid;
      acc_b = rst_n && b_req_valid && !coll;
      acc_h[0][idx] = acc_a;
      acc_h[1][idx] = acc_b;
      if (acc_a) begin
         dat_h[0][0][idx] = mm[a_addr];
         dat_h[1][0][idx] = merge(mm[a_addr], a_wdata, a_we);
      end
      if (acc_b) begin
         dat_h[0][1][idx] = mm[b_addr];
         dat_h[1][1][idx] = merge(mm[b_addr], b_wdata, b_we);
      end
      if (acc_a) mm[a_addr] = merge(mm[a_addr], a_wdata, a_we);
      if (acc_b) mm[b_addr] = merge(mm[b_addr], b_wdata, b_we);
      #1;
      for (int d = 0; d < 2; d++) begin
         lat = d + 1;
         for (int p = 0; p < 2; p++) begin
            m  = (n - lat + 1) % H;
            ev = acc_h[p][m] && !(lat == 2 && rst_h[idx]);
            if (rst_h[idx]) last[d][p] = '0;
            if (ev) last[d][p] = dat_h[d][p][m];
            chk($sformatf("rsp_valid d%0d p%0d c%0d", d, p, n), rsp_v[d][p], ev);
            chk($sformatf("rdata d%0d p%0d c%0d", d, p, n), rsp_d[d][p], last[d][p]);
         end
      end
   endtask

   task automatic set_a(input logic v, input logic [7:0] ad, input logic [3:0] we,
                        input logic [31:0] wd);
      a_req_valid = v; a_addr = ad; a_we = we; a_wdata = wd;
   endtask

   task automatic set_b(input logic v, input logic [7:0] ad, input logic [3:0] we,
                        input logic [31:0] wd);
      b_req_valid = v; b_addr = ad; b_we = we; b_wdata = wd;
   endtask

   initial begin
      logic [31:0] saved0;
      int cnt;
      bit pending;
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) last[d][p] = '0;

      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;

      // Fill every word so later reads have defined contents.
      for (int i = 0; i < 128; i++) begin
         set_a(1, 8'(i), 4'hF, $urandom);
         set_b(1, 8'(i + 128), 4'hF, $urandom);
         step();
      end
      set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
      step();

      // Requests during reset are ignored.
      saved0 = mm[0];
      rst_n = 1'b0;
      set_a(1, 8'h00, 4'hF, ~saved0);
      repeat (3) step();
      rst_n = 1'b1;
      set_a(1, 8'h00, 4'h0, 0);
      step();
      chk("rst_mem0 d0", rsp_d[0][0], saved0);
      set_a(0, 0, 0, 0);
      step();
      chk("rst_mem0 d1", rsp_d[1][0], saved0);

      // Byte strobes.
      set_a(1, 8'h10, 4'hF, 32'hDEADBEEF); step();
      set_a(1, 8'h10, 4'h1, 32'h00000055); step();
      set_a(1, 8'h10, 4'h0, 32'h0);        step();
      chk("strobe d0", rsp_d[0][0], 32'hDEADBE55);
      set_a(0, 0, 0, 0); step();
      chk("strobe d1", rsp_d[1][0], 32'hDEADBE55);

      // Read-during-write.
      set_a(1, 8'h20, 4'hF, 32'h11111111); step();
      set_a(1, 8'h20, 4'h3, 32'h22222222); step();
      chk("rdw read-first", rsp_d[0][0], 32'h11111111);
      set_a(0, 0, 0, 0); step();
      chk("rdw write-first", rsp_d[1][0], 32'h11112222);

      // Collision: A write stalls B read to the same word.
      set_a(1, 8'h30, 4'hF, 32'hAAAAAAAA);
      set_b(1, 8'h30, 4'h0, 32'h0);
      step();
      chk("coll b_ready", b_ready_seen, 0);
      chk("coll a rsp d0", rsp_v[0][0], 1);
      set_a(0, 0, 0, 0);
      step();
      chk("coll b_ready retry", b_ready_seen, 1);
      chk("coll a rsp d1", rsp_v[1][0], 1);
      chk("coll b data d0", rsp_d[0][1], 32'hAAAAAAAA);
      set_b(0, 0, 0, 0);
      step();
      chk("coll b data d1", rsp_d[1][1], 32'hAAAAAAAA);

      // Same-address dual read.
      set_a(1, 8'h40, 4'hF, 32'h12345678); step();
      set_a(1, 8'h40, 4'h0, 0); set_b(1, 8'h40, 4'h0, 0); step();
      chk("dual b_ready", b_ready_seen, 1);
      chk("dual a d0", rsp_d[0][0], 32'h12345678);
      chk("dual b d0", rsp_d[0][1], 32'h12345678);
      set_a(0, 0, 0, 0); set_b(0, 0, 0, 0); step();
      chk("dual a v d1", rsp_v[1][0], 1);
      chk("dual b v d1", rsp_v[1][1], 1);
      chk("dual b d1", rsp_d[1][1], 32'h12345678);

      // Streaming reads on B.
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         set_b(1, 8'(8'h50 + i), 4'h0, 0);
         step();
         if (rsp_v[1][1]) cnt++;
      end
      set_b(0, 0, 0, 0);
      repeat (3) begin step(); if (rsp_v[1][1]) cnt++; end
      chk("stream count d1", 32'(cnt), 8);

      // Reset mid-stream drops remaining responses.
      for (int i = 0; i < 4; i++) begin
         set_b(1, 8'(8'h60 + i), 4'h0, 0);
         step();
      end
      rst_n = 1'b0;
      step();
      chk("midrst b v d1", rsp_v[1][1], 0);
      chk("midrst b d1", rsp_d[1][1], 0);
      chk("midrst a d1", rsp_d[1][0], 0);
      chk("midrst b d0", rsp_d[0][1], 0);
      rst_n = 1'b1;
      set_b(0, 0, 0, 0);
      repeat (2) begin step(); chk("post rst b v d1", rsp_v[1][1], 0); end

      // Randomised traffic on a small address window to provoke collisions.
      pending = 0;
      for (int k = 0; k < 400; k++) begin
         rst_n = ($urandom_range(0, 59) != 0);
         set_a(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 7)),
               ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0, $urandom);
         if (!pending)
            set_b(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0, $urandom);
         step();
         pending = b_req_valid && !b_ready_seen;
      end
      rst_n = 1'b1;
      set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
